// File: rtl/sample_iterator.sv
// Raster sample iterator: latches a triangle and its bounding box, then walks the box
// in raster order at the subsample pitch, one sample per cycle. Optional macro: ITER_MULTISAMPLE_EN.
module sample_iterator #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [SIGFIG-1:0] tri_R13S [VERTS][AXIS],
  input  logic        [SIGFIG-1:0] color_R13U [COLORS],
  input  logic signed [SIGFIG-1:0] box_R13S [2][2],
  input  logic                     validTri_R13H,
  input  logic        [3:0]        subSample_RnnnnU,
  output logic                     halt_RnnnnL,
  output logic signed [SIGFIG-1:0] tri_R14S [VERTS][AXIS],
  output logic        [SIGFIG-1:0] color_R14U [COLORS],
  output logic signed [SIGFIG-1:0] sample_R14S [2],
  output logic                     validSamp_R14H,
  output logic                     state_dbg
);

  // Handshake: the upstream offers a triangle with validTri_R13H; it is taken on any
  // clk edge where halt_RnnnnL is high. While halt_RnnnnL is low, inputs are ignored.
  typedef enum logic {WAIT = 1'b0, TEST = 1'b1} state_t;

  localparam logic [SIGFIG-1:0] STEP_PIX = SIGFIG'(1) << RADIX;

  state_t                    state;
  logic        [SIGFIG-1:0]  step_q;
  logic        [SIGFIG-1:0]  step_next;
  logic signed [SIGFIG-1:0]  ll_x_q;
  logic signed [SIGFIG-1:0]  ur_x_q;
  logic signed [SIGFIG-1:0]  ur_y_q;
  logic                      degen_q;
  logic                      degen_in;
  logic signed [SIGFIG:0]    nx;
  logic signed [SIGFIG:0]    ny;
  logic signed [SIGFIG:0]    ur_x_w;
  logic signed [SIGFIG:0]    ur_y_w;

`ifdef ITER_MULTISAMPLE_EN
  always_comb begin
    step_next = STEP_PIX;
    case (subSample_RnnnnU)
      4'b1000: step_next = SIGFIG'(1) << RADIX;
      4'b0100: step_next = SIGFIG'(1) << (RADIX - 1);
      4'b0010: step_next = SIGFIG'(1) << (RADIX - 2);
      4'b0001: step_next = SIGFIG'(1) << (RADIX - 3);
      default: step_next = STEP_PIX;
    endcase
  end
`else
  logic sub_unused;
  assign sub_unused = ^subSample_RnnnnU;
  assign step_next  = STEP_PIX;
`endif

  // A box inverted on either axis yields only its LL corner.
  assign degen_in = (box_R13S[0][0] > box_R13S[1][0]) || (box_R13S[0][1] > box_R13S[1][1]);

  // One extra bit keeps the step addition and bound compare free of overflow.
  assign nx     = {sample_R14S[0][SIGFIG-1], sample_R14S[0]} + {1'b0, step_q};
  assign ny     = {sample_R14S[1][SIGFIG-1], sample_R14S[1]} + {1'b0, step_q};
  assign ur_x_w = {ur_x_q[SIGFIG-1], ur_x_q};
  assign ur_y_w = {ur_y_q[SIGFIG-1], ur_y_q};

  assign state_dbg = (state == TEST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= WAIT;
      halt_RnnnnL    <= 1'b1;
      validSamp_R14H <= 1'b0;
      step_q         <= STEP_PIX;
      ll_x_q         <= '0;
      ur_x_q         <= '0;
      ur_y_q         <= '0;
      degen_q        <= 1'b0;
      sample_R14S[0] <= '0;
      sample_R14S[1] <= '0;
      for (int v = 0; v < VERTS; v++)
        for (int a = 0; a < AXIS; a++)
          tri_R14S[v][a] <= '0;
      for (int c = 0; c < COLORS; c++)
        color_R14U[c] <= '0;
    end else begin
      case (state)
        WAIT: begin
          if (validTri_R13H) begin
            state          <= TEST;
            halt_RnnnnL    <= 1'b0;
            validSamp_R14H <= 1'b1;
            step_q         <= step_next;
            ll_x_q         <= box_R13S[0][0];
            ur_x_q         <= box_R13S[1][0];
            ur_y_q         <= box_R13S[1][1];
            degen_q        <= degen_in;
            sample_R14S[0] <= box_R13S[0][0];
            sample_R14S[1] <= box_R13S[0][1];
            tri_R14S       <= tri_R13S;
            color_R14U     <= color_R13U;
          end
        end
        TEST: begin
          if (!degen_q && (nx <= ur_x_w)) begin
            sample_R14S[0] <= nx[SIGFIG-1:0];
          end else if (!degen_q && (ny <= ur_y_w)) begin
            sample_R14S[0] <= ll_x_q;
            sample_R14S[1] <= ny[SIGFIG-1:0];
          end else begin
            state          <= WAIT;
            halt_RnnnnL    <= 1'b1;
            validSamp_R14H <= 1'b0;
          end
        end
        default: state <= WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_iterator.sv
// Directed bench for sample_iterator: an independent box-walk model fills an expected
// queue per triangle; a negedge monitor pops and compares every emitted sample.
module tb_sample_iterator;

  localparam int SIGFIG = 24;
  localparam int RADIX  = 10;
  localparam int VERTS  = 3;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;
  localparam int W      = 4 * SIGFIG;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic signed [SIGFIG-1:0] tri_R13S [VERTS][AXIS];
  logic        [SIGFIG-1:0] color_R13U [COLORS];
  logic signed [SIGFIG-1:0] box_R13S [2][2];
  logic                     validTri_R13H = 1'b0;
  logic        [3:0]        subSample_RnnnnU = 4'b1000;
  logic                     halt_RnnnnL;
  logic signed [SIGFIG-1:0] tri_R14S [VERTS][AXIS];
  logic        [SIGFIG-1:0] color_R14U [COLORS];
  logic signed [SIGFIG-1:0] sample_R14S [2];
  logic                     validSamp_R14H;
  logic                     state_dbg;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  sample_iterator #(.SIGFIG(SIGFIG), .RADIX(RADIX), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS)) dut (
    .clk(clk), .rst(rst),
    .tri_R13S(tri_R13S), .color_R13U(color_R13U), .box_R13S(box_R13S),
    .validTri_R13H(validTri_R13H), .subSample_RnnnnU(subSample_RnnnnU),
    .halt_RnnnnL(halt_RnnnnL), .tri_R14S(tri_R14S), .color_R14U(color_R14U),
    .sample_R14S(sample_R14S), .validSamp_R14H(validSamp_R14H), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int step_of(input logic [3:0] s);
`ifdef ITER_MULTISAMPLE_EN
    case (s)
      4'b1000: return 1024;
      4'b0100: return 512;
      4'b0010: return 256;
      4'b0001: return 128;
      default: return 1024;
    endcase
`else
    return 1024;
`endif
  endfunction

  function automatic logic [W-1:0] pack(input int x, input int y, input int base);
    return {SIGFIG'(x), SIGFIG'(y), SIGFIG'(base * 16), SIGFIG'(base)};
  endfunction

  // driver tasks
  task automatic set_inputs(input int llx, input int lly, input int urx, input int ury,
                            input logic [3:0] sub, input int base);
    for (int v = 0; v < VERTS; v++)
      for (int a = 0; a < AXIS; a++)
        tri_R13S[v][a] = SIGFIG'(base + v * AXIS + a);
    for (int c = 0; c < COLORS; c++)
      color_R13U[c] = SIGFIG'(base * 16 + c);
    box_R13S[0][0] = SIGFIG'(llx);
    box_R13S[0][1] = SIGFIG'(lly);
    box_R13S[1][0] = SIGFIG'(urx);
    box_R13S[1][1] = SIGFIG'(ury);
    subSample_RnnnnU = sub;
  endtask

  task automatic push_model(input int llx, input int lly, input int urx, input int ury,
                            input logic [3:0] sub, input int base);
    int st;
    st = step_of(sub);
    if (llx > urx || lly > ury) begin
      exp_q.push_back(pack(llx, lly, base));
    end else begin
      for (int y = lly; y <= ury; y += st)
        for (int x = llx; x <= urx; x += st)
          exp_q.push_back(pack(x, y, base));
    end
  endtask

  // Counts halt-low cycles starting at the negedge after acceptance; bounded.
  task automatic count_busy(output int cnt);
    cnt = 0;
    for (int i = 0; i < 64; i++) begin
      if (halt_RnnnnL) break;
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic walk(input string tag, input int llx, input int lly, input int urx, input int ury,
                      input logic [3:0] sub, input int base, input int exp_n);
    int cnt;
    @(negedge clk);
    set_inputs(llx, lly, urx, ury, sub, base);
    push_model(llx, lly, urx, ury, sub, base);
    validTri_R13H = 1'b1;
    @(posedge clk);
    @(negedge clk);
    validTri_R13H = 1'b0;
    set_inputs(-4000, -4000, 4000, 4000, 4'b0001, 99);
    check({tag, "_state"}, W'(state_dbg), W'(1));
    count_busy(cnt);
    check({tag, "_halt_cycles"}, W'(cnt), W'(exp_n));
    check({tag, "_valid_drop"}, W'(validSamp_R14H), W'(0));
    check({tag, "_queue_empty"}, W'(exp_q.size()), W'(0));
  endtask

  // scoreboard
  always @(negedge clk) begin
    if (validSamp_R14H) begin
      if (exp_q.size() == 0) begin
        check("sample_unexpected", pack(sample_R14S[0], sample_R14S[1], 0), '1);
      end else begin
        check("sample", {sample_R14S[0], sample_R14S[1], color_R14U[0], tri_R14S[0][0]},
              exp_q.pop_front());
      end
    end
  end

  initial begin
    int cnt;
    set_inputs(0, 0, 0, 0, 4'b1000, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_halt", W'(halt_RnnnnL), W'(1));
    check("rst_valid", W'(validSamp_R14H), W'(0));
    check("rst_state", W'(state_dbg), W'(0));
    check("rst_sample", W'({sample_R14S[0], sample_R14S[1]}), W'(0));
    check("rst_tri", W'(tri_R14S[2][2]), W'(0));
    check("rst_color", W'(color_R14U[2]), W'(0));
    rst = 1'b0;

    walk("box6", 0, 0, 2048, 1024, 4'b1000, 1, 6);
    walk("point", 512, 512, 512, 512, 4'b1000, 2, 1);
`ifdef ITER_MULTISAMPLE_EN
    walk("half", 0, 0, 700, 512, 4'b0100, 3, 4);
    walk("eighth", 0, 0, 256, 128, 4'b0001, 4, 6);
`else
    walk("half", 0, 0, 700, 512, 4'b0100, 3, 1);
    walk("eighth", 0, 0, 256, 128, 4'b0001, 4, 1);
`endif
    walk("nonhot", 0, 0, 1024, 0, 4'b0011, 6, 2);
    walk("negbox", -1024, -1024, 0, 0, 4'b1000, 7, 4);
    walk("degen", 1024, 0, 0, 0, 4'b1000, 8, 1);

    // back-to-back: validTri stays high, second triangle waits for halt
    @(negedge clk);
    set_inputs(0, 0, 2048, 1024, 4'b1000, 10);
    push_model(0, 0, 2048, 1024, 4'b1000, 10);
    validTri_R13H = 1'b1;
    @(posedge clk);
    @(negedge clk);
    set_inputs(-1024, -1024, 0, 0, 4'b1000, 11);
    push_model(-1024, -1024, 0, 0, 4'b1000, 11);
    count_busy(cnt);
    check("b2b_first_cycles", W'(cnt), W'(6));
    check("b2b_gap_valid", W'(validSamp_R14H), W'(0));
    @(posedge clk);
    @(negedge clk);
    validTri_R13H = 1'b0;
    check("b2b_second_valid", W'(validSamp_R14H), W'(1));
    count_busy(cnt);
    check("b2b_second_cycles", W'(cnt), W'(4));
    check("b2b_queue_empty", W'(exp_q.size()), W'(0));

    // reset on the third sample of a six-sample walk
    @(negedge clk);
    set_inputs(0, 0, 2048, 1024, 4'b1000, 5);
    push_model(0, 0, 2048, 1024, 4'b1000, 5);
    validTri_R13H = 1'b1;
    @(posedge clk);
    @(negedge clk);
    validTri_R13H = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_valid", W'(validSamp_R14H), W'(0));
    check("abort_halt", W'(halt_RnnnnL), W'(1));
    check("abort_sample", W'({sample_R14S[0], sample_R14S[1]}), W'(0));
    check("abort_tri", W'(tri_R14S[0][0]), W'(0));
    check("abort_remaining", W'(exp_q.size()), W'(3));
    exp_q.delete();
    rst = 1'b0;
    walk("after_rst", 1024, 1024, 2048, 1024, 4'b1000, 12, 2);

    repeat (3) @(negedge clk);
    check("idle_valid", W'(validSamp_R14H), W'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
